// File: rtl/store_buffer_pkg.sv
// Shared core package for the store buffer.
// Holds the default depth, the byte-enable width and the layout of one
// buffered store (word-aligned data with its byte-lane enables).
package store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_ADDR_W        = 32;
  localparam int SB_DATA_W        = 32;
  localparam int SB_BE_W          = 4;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_BE_W-1:0]   be;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Priority matcher for store-to-load forwarding.
// Compares every live entry against the load's word address and returns the
// payload of the youngest matching entry; no merging across entries.
// Ports:
//   entries  - full entry array of the buffer
//   head     - index of the oldest live entry
//   count    - number of live entries
//   ld_addr  - load address (only bits [31:2] are compared)
//   hit      - some live entry matches
//   data/be  - payload of the youngest match, 0 when no match
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [SB_ADDR_W-1:0]       ld_addr,
  output logic                       hit,
  output logic [SB_DATA_W-1:0]       data,
  output logic [SB_BE_W-1:0]         be
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] addr_lsb_fold;
  logic [PTR_W-1:0] idx;
  logic             unused_bits;

  // An entry is live when its distance from head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] age;
    assign age               = PTR_W'(gi) - head;
    assign match[gi]         = ({1'b0, age} < count) &&
                               (entries[gi].addr[31:2] == ld_addr[31:2]);
    assign addr_lsb_fold[gi] = ^entries[gi].addr[1:0];
  end

  // Byte offsets are kept with the entry but never take part in matching.
  assign unused_bits = ^{addr_lsb_fold, ld_addr[1:0]};

  // Walk oldest to youngest; a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    be   = '0;
    idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (match[idx]) begin
        hit  = 1'b1;
        data = entries[idx].data;
        be   = entries[idx].be;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and the data cache.
// Circular FIFO of DEPTH stores; the head store is offered to the cache and
// popped on wr_ack. Optional store-to-load forwarding is compiled in with the
// macro STORE_BUFFER_FWD_EN; without it the forwarding outputs are tied to 0.
// Ports:
//   clk, rst (synchronous, active-low)
//   enq_valid/enq_addr/enq_data/enq_be, enq_ready - store from MEM stage
//   wr_req/wr_addr/wr_data/wr_be, wr_ack         - head store to the cache
//   ld_req/ld_addr, fwd_hit/fwd_data/fwd_be      - load forwarding lookup
//   empty, full                                  - occupancy status
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_valid,
  input  logic [SB_ADDR_W-1:0] enq_addr,
  input  logic [SB_DATA_W-1:0] enq_data,
  input  logic [SB_BE_W-1:0]   enq_be,
  output logic                 enq_ready,
  output logic                 wr_req,
  output logic [SB_ADDR_W-1:0] wr_addr,
  output logic [SB_DATA_W-1:0] wr_data,
  output logic [SB_BE_W-1:0]   wr_be,
  input  logic                 wr_ack,
  input  logic [SB_ADDR_W-1:0] ld_addr,
  input  logic                 ld_req,
  output logic                 fwd_hit,
  output logic [SB_DATA_W-1:0] fwd_data,
  output logic [SB_BE_W-1:0]   fwd_be,
  output logic                 empty,
  output logic                 full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t         entries [DEPTH];
  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              do_enq, do_pop;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign enq_ready = !full;
  assign wr_req    = !empty;

  // Enqueue is refused while full even if the head pops this cycle.
  assign do_enq = enq_valid && !full;
  assign do_pop = wr_req && wr_ack;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (do_enq) tail_next = tail_reg + 1'b1;
    if (do_pop) head_next = head_reg + 1'b1;
    case ({do_enq, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Payload needs no reset: liveness comes from head/count alone.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      entries[tail_reg] <= '{addr: enq_addr, data: enq_data, be: enq_be};
    end
  end

  // Stale payload is masked so an empty buffer drives zeros.
  assign wr_addr = empty ? '0 : entries[head_reg].addr;
  assign wr_data = empty ? '0 : entries[head_reg].data;
  assign wr_be   = empty ? '0 : entries[head_reg].be;

`ifdef STORE_BUFFER_FWD_EN
  logic                 match_hit;
  logic [SB_DATA_W-1:0] match_data;
  logic [SB_BE_W-1:0]   match_be;

  // Matching uses registered state only, so a store enqueued this cycle is
  // invisible while the one being popped still forwards.
  sb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_match (
    .entries (entries),
    .head    (head_reg),
    .count   (count_reg),
    .ld_addr (ld_addr),
    .hit     (match_hit),
    .data    (match_data),
    .be      (match_be)
  );

  assign fwd_hit  = ld_req && match_hit;
  assign fwd_data = fwd_hit ? match_data : '0;
  assign fwd_be   = fwd_hit ? match_be   : '0;
`else
  logic unused_ld;

  assign fwd_hit   = 1'b0;
  assign fwd_data  = '0;
  assign fwd_be    = '0;
  assign unused_ld = ^{ld_addr, ld_req};
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [31:0] enq_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_be;
  logic        enq_ready;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_ack;
  logic [31:0] ld_addr;
  logic        ld_req;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_be;
  logic        empty;
  logic        full;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_addr  (enq_addr),
    .enq_data  (enq_data),
    .enq_be    (enq_be),
    .enq_ready (enq_ready),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .wr_ack    (wr_ack),
    .ld_addr   (ld_addr),
    .ld_req    (ld_req),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .fwd_be    (fwd_be),
    .empty     (empty),
    .full      (full)
  );

  // Reference model: an ordered queue of stores, oldest at index 0.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } ent_t;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, check outputs against
  // the model's pre-edge state, then advance the model at the rising edge.
  task automatic step(input logic r, input logic ev, input logic [31:0] ea,
                      input logic [31:0] ed, input logic [3:0] eb,
                      input logic ack, input logic lr, input logic [31:0] la);
    logic        e_hit;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic        m_empty, m_full, acc, pop;
    ent_t        ne;
    rst = r; enq_valid = ev; enq_addr = ea; enq_data = ed; enq_be = eb;
    wr_ack = ack; ld_req = lr; ld_addr = la;
    #1;
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == DEPTH);
    e_hit = 1'b0; e_data = '0; e_be = '0;
`ifdef STORE_BUFFER_FWD_EN
    if (lr) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a[31:2] == la[31:2]) begin
          e_hit = 1'b1; e_data = mq[i].d; e_be = mq[i].b;
          break;
        end
      end
    end
`endif
    check("empty",     32'(empty),     32'(m_empty));
    check("full",      32'(full),      32'(m_full));
    check("enq_ready", 32'(enq_ready), 32'(!m_full));
    check("wr_req",    32'(wr_req),    32'(!m_empty));
    check("wr_addr",   wr_addr,        m_empty ? 32'h0 : mq[0].a);
    check("wr_data",   wr_data,        m_empty ? 32'h0 : mq[0].d);
    check("wr_be",     32'(wr_be),     m_empty ? 32'h0 : 32'(mq[0].b));
    check("fwd_hit",   32'(fwd_hit),   32'(e_hit));
    check("fwd_data",  fwd_data,       e_data);
    check("fwd_be",    32'(fwd_be),    32'(e_be));
    acc = ev && !m_full;
    pop = !m_empty && ack;
    $display("t=%0t rst=%0b enq=%0b acc=%0b a=%h d=%h be=%h pop=%0b ld=%0b la=%h hit=%0b fd=%h occ=%0d",
             $time, r, ev, acc && r, ea, ed, eb, pop && r, lr, la, fwd_hit, fwd_data, mq.size());
    @(posedge clk);
    if (!r) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        ne.a = ea; ne.d = ed; ne.b = eb;
        mq.push_back(ne);
      end
    end
    @(negedge clk);
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    step(1'b1, 1'b1, a, d, b, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle(input logic ack);
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, ack, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_be = '0;
    wr_ack = 1'b0; ld_req = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then single enqueue with one cycle of latency.
    idle(1'b0);
    enq(32'h100, 32'hDEADBEEF, 4'hF);
    check("lat_wr_req",  32'(wr_req), 32'h1);
    check("lat_wr_addr", wr_addr, 32'h100);
    check("lat_wr_data", wr_data, 32'hDEADBEEF);
    check("lat_empty",   32'(empty), 32'h0);

    // Fill to DEPTH, try a fifth, then pop once.
    enq(32'h104, 32'h1, 4'h1);
    enq(32'h108, 32'h2, 4'h2);
    enq(32'h10C, 32'h3, 4'h4);
    check("fill_full",      32'(full), 32'h1);
    check("fill_enq_ready", 32'(enq_ready), 32'h0);
    enq(32'h110, 32'h4, 4'h8);
    step(1'b1, 1'b1, 32'h114, 32'h5, 4'hF, 1'b1, 1'b0, 32'h0);
    check("pop_enq_ready", 32'(enq_ready), 32'h1);
    check("pop_head",      wr_addr, 32'h104);
    repeat (4) idle(1'b1);
    check("drain_empty", 32'(empty), 32'h1);

    // Forwarding picks the youngest word match only.
    do_reset();
    enq(32'h200, 32'h1111, 4'h3);
    enq(32'h202, 32'h22220000, 4'hC);
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h200);
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_ex_hit",  32'(fwd_hit), 32'h1);
    check("fwd_ex_data", fwd_data, 32'h22220000);
    check("fwd_ex_be",   32'(fwd_be), 32'hC);
`else
    check("fwd_ex_hit",  32'(fwd_hit), 32'h0);
    check("fwd_ex_be",   32'(fwd_be), 32'h0);
`endif

    // Full-rate enqueue/pop pairs wrapping the pointers.
    do_reset();
    enq(32'h400, 32'hA0, 4'hF);
    for (int k = 1; k <= 8; k++)
      step(1'b1, 1'b1, 32'h400 + 32'(4 * k), 32'hA0 + 32'(k), 4'hF, 1'b1, 1'b0, 32'h0);
    check("wrap_head", wr_addr, 32'h420);
    check("wrap_full", 32'(full), 32'h0);

    // Reset during a drain discards everything.
    do_reset();
    enq(32'h500, 32'h1, 4'hF);
    enq(32'h504, 32'h2, 4'hF);
    enq(32'h508, 32'h3, 4'hF);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    check("rst_drain_empty",  32'(empty), 32'h1);
    check("rst_drain_wr_req", 32'(wr_req), 32'h0);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic over a small address pool to force matches.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) != 0),
           ($urandom_range(0, 2) != 0),
           32'h300 + 32'($urandom_range(0, 15)),
           $urandom,
           4'($urandom),
           ($urandom_range(0, 1) != 0),
           ($urandom_range(0, 1) != 0),
           32'h300 + 32'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
